fb_reader: RTL

FB_READER -- requirements
Module: fb_reader

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_skid.sv | 59 +++++
 rtl/fb_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, scan FSM encoding and address helper.
package fb_pkg;

  localparam int unsigned H_RES   = 320;
  localparam int unsigned V_RES   = 240;
  localparam int unsigned FB_SIZE = H_RES * V_RES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  // Row start address (row * h) built from shifted additions of h.
  function automatic int unsigned row_base(input logic [7:0] row, input int unsigned h);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (row[i]) acc = acc + (h << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_skid.sv
// Two-entry output buffer with valid/ready on both sides; head drives the output.
module fb_skid #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;
  logic [1:0]   cnt_d;

  // Handshakes and next occupancy.
  always_comb begin
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    cnt_d = level + 2'(push) - 2'(pop);
  end

  // Head/tail storage; flags registered from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      tail_q    <= '0;
      level     <= 2'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      level     <= cnt_d;
      out_valid <= (cnt_d != 2'd0);
      in_ready  <= (cnt_d != 2'd2);
      case ({push, pop})
        2'b10: begin
          if (level == 2'd0) out_data <= in_data;
          else               tail_q   <= in_data;
        end
        2'b01: out_data <= tail_q;
        2'b11: begin
          if (level == 2'd1) begin
            out_data <= in_data;
          end else begin
            out_data <= tail_q;
            tail_q   <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fb_reader.sv
// Framebuffer scan-out: reads one frame with waterfall row offset, streams pixels.
module fb_reader #(
  parameter int unsigned H_RES  = fb_pkg::H_RES,
  parameter int unsigned V_RES  = fb_pkg::V_RES,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        row_offset,
  output logic              busy,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
);

  import fb_pkg::*;

  localparam int unsigned XW    = $clog2(H_RES + 1);
  localparam int unsigned YW    = $clog2(V_RES + 1);
  localparam int unsigned FB_SZ = H_RES * V_RES;

  logic [1:0]        rst_sync;
  logic              rst_n;
  fb_state_e         state_q, state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] base_q, base_inc, start_base;
  logic [7:0]        off_eff;
  logic              rd_pend, pend_sof, pend_eol;
  logic              issue, accept, last_rd, pop;
  logic [1:0]        occ, sk_level;
  logic              sk_in_ready;
  logic [DATA_W+1:0] sk_out;

  assign mem_wen = 1'b0;

  // Reset asserts immediately, releases after two clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Read issue decision and address arithmetic (additions only).
  always_comb begin
    pop        = pix_valid && pix_ready;
    occ        = sk_level - 2'(pop) + 2'(rd_pend);
    accept     = (state_q == ST_IDLE) && start;
    issue      = (state_q == ST_RUN) && mem_grant && (occ < 2'd2) && (sk_in_ready || pop);
    last_rd    = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
    off_eff    = (32'(row_offset) >= V_RES) ? 8'd0 : row_offset;
    start_base = ADDR_W'(row_base(off_eff, H_RES));
    base_inc   = base_q + ADDR_W'(H_RES);
    if (base_inc == ADDR_W'(FB_SZ)) base_inc = '0;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (issue && last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_pend && ((sk_level == 2'd0) || ((sk_level == 2'd1) && pop)))
                  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

  // Scan counters, address register and in-flight read tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      base_q   <= '0;
      mem_addr <= '0;
      rd_pend  <= 1'b0;
      pend_sof <= 1'b0;
      pend_eol <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        pend_sof <= (x_q == '0) && (y_q == '0);
        pend_eol <= (x_q == XW'(H_RES - 1));
      end
      if (accept) begin
        x_q      <= '0;
        y_q      <= '0;
        base_q   <= start_base;
        mem_addr <= start_base;
      end else if (issue && !last_rd) begin
        if (x_q == XW'(H_RES - 1)) begin
          x_q      <= '0;
          y_q      <= y_q + YW'(1);
          base_q   <= base_inc;
          mem_addr <= base_inc;
        end else begin
          x_q      <= x_q + XW'(1);
          mem_addr <= mem_addr + ADDR_W'(1);
        end
      end
    end
  end

  fb_skid #(.W(DATA_W + 2)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_pend),
    .in_ready  (sk_in_ready),
    .in_data   ({pend_sof, pend_eol, mem_rdata}),
    .out_valid (pix_valid),
    .out_ready (pix_ready),
    .out_data  (sk_out),
    .level     (sk_level)
  );

  assign pix_data = sk_out[DATA_W-1:0];
  assign pix_eol  = sk_out[DATA_W];
  assign pix_sof  = sk_out[DATA_W+1];

endmodule
